// File: rtl/aq_shift_reg_if.sv
// -----------------------------------------------------------------------------
// aq_shift_reg_if
// Purpose : groups the data, control and status signals of aq_shift_reg.
// Ports   : in, in_enable, op, shamt, lsb_in, out_enable  -> driven by master
//           out, count, done, state                       -> driven by slave
// Handshake: there is no valid/ready pair. Any value on the control signals
//           while in_enable=1 is consumed on every rising clock edge, and
//           in_enable=0 means "no transfer this cycle". The status signals
//           count, done and state are registered; out is combinational from
//           the register.
// -----------------------------------------------------------------------------
interface aq_shift_reg_if #(
    parameter int WIDTH = 64,
    parameter int CW    = 6
);
    logic [WIDTH-1:0] in;
    logic             in_enable;
    logic [1:0]       op;
    logic             shamt;
    logic [1:0]       lsb_in;
    logic             out_enable;
    logic [WIDTH-1:0] out;
    logic [CW-1:0]    count;
    logic             done;
    logic [1:0]       state;      // debug view: 0 IDLE, 1 RUN, 2 DONE

    modport master (
        output in, in_enable, op, shamt, lsb_in, out_enable,
        input  out, count, done, state
    );

    modport slave (
        input  in, in_enable, op, shamt, lsb_in, out_enable,
        output out, count, done, state
    );
endinterface

// File: rtl/aq_shift_reg.sv
// -----------------------------------------------------------------------------
// aq_shift_reg
// Purpose : loadable shift register that performs STEPS shift operations per
//           run and then freezes (done) until the next load.
// Ports   : clock  - sole clock, rising edge
//           reset  - asynchronous, active-low reset
//           bus    - aq_shift_reg_if.slave (in, in_enable, op, shamt, lsb_in,
//                    out_enable, out, count, done, state)
// op      : 00 hold, 01 load, 10 arithmetic shift right, 11 logical shift left
// Config  : define AQ_SHIFT_REG_TRISTATE_EN to drive out to high-impedance when
//           out_enable=0; by default out is driven to zero instead.
// -----------------------------------------------------------------------------
module aq_shift_reg #(
    parameter int WIDTH = 64,
    parameter int STEPS = 32,
    parameter int CW    = 6
) (
    input  logic           clock,
    input  logic           reset,
    aq_shift_reg_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0]    OP_HOLD  = 2'b00;
    localparam logic [1:0]    OP_LOAD  = 2'b01;
    localparam logic [1:0]    OP_ASR   = 2'b10;
    localparam logic [1:0]    OP_LSL   = 2'b11;
    localparam logic [CW-1:0] STEPS_C  = CW'(STEPS);

    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    count_q, count_d;
    logic             done_q, done_d;
    state_t           state_q, state_d;

    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    count_inc;

    // Shift result for the current op; only used when a shift executes.
    always_comb begin
        shifted = data_q;
        if (bus.op == OP_ASR) begin
            if (bus.shamt)
                shifted = {{2{data_q[WIDTH-1]}}, data_q[WIDTH-1:2]};
            else
                shifted = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
        end else if (bus.op == OP_LSL) begin
            if (bus.shamt)
                shifted = {data_q[WIDTH-3:0], bus.lsb_in};
            else
                shifted = {data_q[WIDTH-2:0], bus.lsb_in[0]};
        end
    end

    assign count_inc = count_q + 1'b1;

    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        done_d  = done_q;
        state_d = state_q;
        if (bus.in_enable) begin
            case (bus.op)
                OP_LOAD: begin
                    data_d  = bus.in;
                    count_d = '0;
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
                OP_ASR, OP_LSL: begin
                    // Once done, shifts are ignored so count cannot pass STEPS.
                    if (!done_q) begin
                        data_d  = shifted;
                        count_d = count_inc;
                        done_d  = (count_inc == STEPS_C);
                        state_d = (count_inc == STEPS_C) ? DONE : RUN;
                    end
                end
                OP_HOLD: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            state_q <= IDLE;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
            done_q  <= done_d;
            state_q <= state_d;
        end
    end

    assign bus.count = count_q;
    assign bus.done  = done_q;
    assign bus.state = state_q;

`ifdef AQ_SHIFT_REG_TRISTATE_EN
    assign bus.out = bus.out_enable ? data_q : {WIDTH{1'bz}};
`else
    assign bus.out = bus.out_enable ? data_q : '0;
`endif

endmodule

// File: tb/tb_aq_shift_reg.sv
module tb_aq_shift_reg;
  localparam int W  = 8;
  localparam int S  = 4;
  localparam int CW = 3;

  logic clock;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  aq_shift_reg_if #(.WIDTH(W), .CW(CW)) bus ();

  aq_shift_reg #(.WIDTH(W), .STEPS(S), .CW(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  logic [W-1:0]  m_q;
  logic [CW-1:0] m_count;
  logic          m_done;
  logic [W+CW:0] exp_q[$];   // {done, count, q}

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = '0;
    m_count = '0;
    m_done = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic [1:0] op, input logic sh,
                            input logic [1:0] lsb, input logic [W-1:0] din);
    logic signed [W-1:0] s;
    int n;
    n = sh ? 2 : 1;
    if (en) begin
      if (op == 2'b01) begin
        m_q = din;
        m_count = '0;
        m_done = 1'b0;
      end else if (op[1] && !m_done) begin
        if (op == 2'b10) begin
          s = m_q;
          m_q = s >>> n;
        end else begin
          m_q = m_q << n;
          m_q = m_q | (sh ? {6'b0, lsb} : {7'b0, lsb[0]});
        end
        m_count = m_count + 1'b1;
        if (int'(m_count) == S) m_done = 1'b1;
      end
    end
  endtask

  function automatic logic [1:0] exp_state(input logic d, input logic [CW-1:0] c);
    if (d) return 2'd2;
    if (c == 0) return 2'd0;
    return 2'd1;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic en, input logic [1:0] op, input logic sh,
                      input logic [1:0] lsb, input logic [W-1:0] din);
    logic [W+CW:0] e;
    @(negedge clock);
    bus.in_enable = en;
    bus.op        = op;
    bus.shamt     = sh;
    bus.lsb_in    = lsb;
    bus.in        = din;
    model_step(en, op, sh, lsb, din);
    exp_q.push_back({m_done, m_count, m_q});
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check_eq("q",     64'(bus.out),   64'(e[W-1:0]));
    check_eq("count", 64'(bus.count), 64'(e[W+CW-1:W]));
    check_eq("done",  64'(bus.done),  64'(e[W+CW]));
    check_eq("state", 64'(bus.state), 64'(exp_state(e[W+CW], e[W+CW-1:W])));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.in_enable  = 1'b0;
    bus.op         = 2'b00;
    bus.shamt      = 1'b0;
    bus.lsb_in     = 2'b00;
    bus.in         = '0;
    bus.out_enable = 1'b1;
    reset          = 1'b0;
    model_reset();
    #12;
    check_eq("rst_q",     64'(bus.out),   64'h0);
    check_eq("rst_count", 64'(bus.count), 64'h0);
    check_eq("rst_done",  64'(bus.done),  64'h0);
    @(negedge clock);
    reset = 1'b1;

    // arithmetic shift right by 2
    step(1, 2'b01, 0, 2'b00, 8'h96);
    step(1, 2'b10, 1, 2'b00, 8'h00);
    check_eq("asr_const", 64'(bus.out), 64'hE5);
    check_eq("asr_cnt",   64'(bus.count), 64'd1);

    // logical shift left by 2 with lsb fill
    step(1, 2'b01, 0, 2'b00, 8'h96);
    step(1, 2'b11, 1, 2'b10, 8'h00);
    check_eq("lsl_const", 64'(bus.out), 64'h5A);
    check_eq("lsl_cnt",   64'(bus.count), 64'd1);

    // single-bit shifts
    step(1, 2'b11, 0, 2'b01, 8'h00);
    step(1, 2'b10, 0, 2'b00, 8'h00);

    // run to done, then extra shifts are frozen
    step(1, 2'b01, 0, 2'b00, 8'hA5);
    for (int i = 0; i < 6; i++) begin
      step(1, {1'b1, i[0]}, i[1], 2'b11, 8'h00);
      if (i == 2) check_eq("done_early", 64'(bus.done), 64'd0);
      if (i == 3) check_eq("done_rise",  64'(bus.done), 64'd1);
    end
    check_eq("frozen_cnt", 64'(bus.count), 64'd4);
    step(1, 2'b00, 0, 2'b00, 8'h00);
    step(1, 2'b01, 0, 2'b00, 8'h3C);
    check_eq("load_clr", 64'(bus.done), 64'd0);

    // in_enable=0 blocks a load
    step(1, 2'b10, 0, 2'b00, 8'h00);
    step(0, 2'b01, 0, 2'b00, 8'hFF);
    check_eq("noen_cnt", 64'(bus.count), 64'd1);

    // output enable
    @(negedge clock);
    bus.out_enable = 1'b0;
    #1;
`ifdef AQ_SHIFT_REG_TRISTATE_EN
    check_eq("oe_off", 64'(bus.out), {56'h0, 8'bzzzzzzzz});
`else
    check_eq("oe_off", 64'(bus.out), 64'h0);
`endif
    bus.out_enable = 1'b1;
    #1;
    check_eq("oe_on", 64'(bus.out), 64'(m_q));

    // asynchronous reset mid-cycle with q loaded
    step(1, 2'b01, 0, 2'b00, 8'h7E);
    step(1, 2'b11, 0, 2'b01, 8'h00);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_eq("arst_q",     64'(bus.out),   64'h0);
    check_eq("arst_count", 64'(bus.count), 64'h0);
    check_eq("arst_done",  64'(bus.done),  64'h0);
    @(negedge clock);
    reset = 1'b1;
    step(1, 2'b01, 0, 2'b00, 8'hC3);   // first edge after release
    check_eq("post_rst_load", 64'(bus.out), 64'hC3);

    // random traffic
    for (int i = 0; i < 80; i++) begin
      step(($urandom_range(0, 9) != 0),
           2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)),
           8'($urandom_range(0, 255)));
    end

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL exp_q: got %0d leftover expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
